// File: rtl/uart_cmd_rx_pkg.sv
// Shared types and constants for the UART command receiver.
package uart_cmd_rx_pkg;

  // Receiver sequencing states. The bit-timing states (START/DATA/STOP)
  // live in uart_rx_byte. The top level uses START to mean
  // "a byte is in flight in the byte receiver".
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    GAP       = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_e;

  // 125 MHz / 115200 baud
  localparam int DefBaudRateDivider = 1085;

  // Field layout of a 32-bit MDIO command word
  localparam int CmdPhyLsb  = 0;
  localparam int CmdPhyW    = 5;
  localparam int CmdRegLsb  = 5;
  localparam int CmdRegW    = 5;
  localparam int CmdCtrlLsb = 10;
  localparam int CmdCtrlW   = 4;
  localparam int CmdOpLsb   = 14;
  localparam int CmdOpW     = 2;
  localparam int CmdDataLsb = 16;
  localparam int CmdDataW   = 16;

endpackage

// File: rtl/uart_cmd_rx_if.sv
// Command valid/ready channel from the UART framer to the MDIO stage.
interface uart_cmd_rx_if #(
  parameter int BytesPerCmd = 4
);
  logic [8*BytesPerCmd-1:0] cmd_data;
  logic                     cmd_valid;
  logic                     cmd_ready;

  modport master (output cmd_data, output cmd_valid, input cmd_ready);
  modport slave  (input cmd_data, input cmd_valid, output cmd_ready);
endinterface

// File: rtl/uart_cmd_rx_byte.sv
// 8N1 byte receiver: rxd synchronizer plus start/data/stop bit timing.
// Emits one-cycle pulses for a good byte, a bad stop bit or a false start.
module uart_rx_byte
  import uart_cmd_rx_pkg::*;
#(
  parameter int BaudRateDivider = DefBaudRateDivider
) (
  input  logic       clk125,
  input  logic       reset,
  input  logic       rxd,
  input  logic       enable,      // allowed to start on a low line
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err,
  output logic       false_start,
  output logic       line_idle    // synchronized line level
);
  localparam int DW = $clog2(BaudRateDivider);
  localparam logic [DW-1:0] HalfLoad = DW'(BaudRateDivider / 2 - 1);
  localparam logic [DW-1:0] FullLoad = DW'(BaudRateDivider - 1);

  logic            sync1, rxs;
  rx_state_e       state, state_n;
  logic [DW-1:0]   delay, delay_n;
  logic [3:0]      bit_cnt, bit_cnt_n;
  logic [7:0]      shreg, shreg_n;

  assign rx_byte   = shreg;
  assign line_idle = rxs;

  // Synchronizer and bit-timing registers
  always_ff @(posedge clk125) begin
    if (reset) begin
      sync1   <= 1'b1;
      rxs     <= 1'b1;
      state   <= IDLE;
      delay   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      sync1   <= rxd;
      rxs     <= sync1;
      state   <= state_n;
      delay   <= delay_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
    end
  end

  // Next-state: sample mid-bit, LSB arrives first so shift in from the top
  always_comb begin
    state_n     = state;
    delay_n     = delay;
    bit_cnt_n   = bit_cnt;
    shreg_n     = shreg;
    byte_valid  = 1'b0;
    frame_err   = 1'b0;
    false_start = 1'b0;
    case (state)
      IDLE: if (enable && !rxs) begin
        state_n = START;
        delay_n = HalfLoad;
      end
      START: begin
        if (delay != '0) delay_n = delay - DW'(1);
        else if (rxs) begin
          false_start = 1'b1;
          state_n     = IDLE;
        end else begin
          delay_n   = FullLoad;
          bit_cnt_n = '0;
          state_n   = DATA;
        end
      end
      DATA: begin
        if (delay != '0) delay_n = delay - DW'(1);
        else begin
          shreg_n   = {rxs, shreg[7:1]};
          delay_n   = FullLoad;
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (delay != '0) delay_n = delay - DW'(1);
        else begin
          state_n    = IDLE;
          byte_valid = rxs;
          frame_err  = !rxs;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: rtl/uart_cmd_rx.sv
// UART command framer: gathers BytesPerCmd bytes into one command word,
// discards partial commands on timeout/framing error, and presents the
// word on a valid/ready channel that never back-pressures the receiver.
module uart_cmd_rx
  import uart_cmd_rx_pkg::*;
#(
  parameter int BaudRateDivider = DefBaudRateDivider,
  parameter int BytesPerCmd     = 4,
  parameter int TimeoutCycles   = 16777215
) (
  input  logic               clk125,
  input  logic               reset,
  input  logic               rxd,
  uart_cmd_rx_if.master      cmd,
  output logic               frame_err,
  output logic               timeout,
  output logic               overflow,
  output logic               busy
);
  localparam logic [23:0] GapLoad  = 24'(TimeoutCycles);
  localparam logic [2:0]  LastByte = 3'(BytesPerCmd - 1);

  typedef logic [BytesPerCmd-1:0][7:0] word_t;

  logic       rx_bv, rx_fe, rx_fs, rxs, rx_en;
  logic [7:0] rx_byte;

  rx_state_e   state, state_n;
  logic [2:0]  byte_cnt, byte_cnt_n;
  logic [23:0] gap_tmr, gap_tmr_n;
  logic        to_n, complete;
  word_t       asm_q, word;
  logic [8*BytesPerCmd-1:0] data_q;
  logic        valid_q;

  assign rx_en         = (state == IDLE) || (state == GAP);
  assign busy          = (state != IDLE);
  assign cmd.cmd_data  = data_q;
  assign cmd.cmd_valid = valid_q;

  uart_rx_byte #(.BaudRateDivider(BaudRateDivider)) u_byte (
    .clk125      (clk125),
    .reset       (reset),
    .rxd         (rxd),
    .enable      (rx_en),
    .byte_valid  (rx_bv),
    .rx_byte     (rx_byte),
    .frame_err   (rx_fe),
    .false_start (rx_fs),
    .line_idle   (rxs)
  );

  // Merge the just-received byte into its slot of the partial word
  always_comb begin
    word = asm_q;
    for (int i = 0; i < BytesPerCmd; i++)
      if (byte_cnt == 3'(i)) word[i] = rx_byte;
  end

  // Sequencing state registers
  always_ff @(posedge clk125) begin
    if (reset) begin
      state    <= IDLE;
      byte_cnt <= '0;
      gap_tmr  <= '0;
      asm_q    <= '0;
    end else begin
      state    <= state_n;
      byte_cnt <= byte_cnt_n;
      gap_tmr  <= gap_tmr_n;
      if (rx_bv) asm_q <= word;
    end
  end

  // Inter-byte sequencing: a start bit in GAP wins over timer expiry
  always_comb begin
    state_n    = state;
    byte_cnt_n = byte_cnt;
    gap_tmr_n  = gap_tmr;
    to_n       = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: if (!rxs) state_n = START;
      START: begin
        if (rx_fe) begin
          byte_cnt_n = '0;
          state_n    = WAIT_HIGH;
        end else if (rx_bv) begin
          if (byte_cnt == LastByte) begin
            complete   = 1'b1;
            byte_cnt_n = '0;
            state_n    = IDLE;
          end else begin
            byte_cnt_n = byte_cnt + 3'd1;
            gap_tmr_n  = GapLoad;
            state_n    = GAP;
          end
        end else if (rx_fs) begin
          if (byte_cnt == '0) state_n = IDLE;
          else begin
            gap_tmr_n = GapLoad;
            state_n   = GAP;
          end
        end
      end
      GAP: begin
        if (!rxs) state_n = START;
        else if (gap_tmr == '0) begin
          to_n       = 1'b1;
          byte_cnt_n = '0;
          state_n    = IDLE;
        end else gap_tmr_n = gap_tmr - 24'd1;
      end
      WAIT_HIGH: if (rxs) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output register and error pulses; a full, unaccepted slot drops the new word
  always_ff @(posedge clk125) begin
    if (reset) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      frame_err <= 1'b0;
      timeout   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= rx_fe;
      timeout   <= to_n;
      overflow  <= 1'b0;
      if (complete) begin
        if (!valid_q || cmd.cmd_ready) begin
          data_q  <= word;
          valid_q <= 1'b1;
        end else overflow <= 1'b1;
      end else if (valid_q && cmd.cmd_ready) valid_q <= 1'b0;
    end
  end

endmodule
